timer_multi_sb_ctrl: RTL
========================

Name: timer_multi_sb_ctrl

Overview:
- Parametrised multi-channel system-bus timer. Successor of the single-channel timer controller.
- Provides CHANNELS independent delay counters, each with OFF/NTIMES/FOREVER modes, plus a shared 64-bit free-running system counter.
- Per-channel interrupts are latched into a pending register (write-1-to-clear) and masked, then ORed into one level interrupt toward the interrupt controller.
- Sits on the processor system bus as a memory-mapped peripheral.

Parameters:
- CHANNELS, 4, number of timer channels (1..8).
- CNT_W, 32, width of the per-channel DELAY, REP_CNT and current-count registers (1..32). Register reads are zero-extended to 32 bits; writes are truncated to CNT_W.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  bus request; held until ready_o is seen.
- write_enable_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address; bits [1:0] ignored.
- write_data_i  in  32  write data.
- read_data_o  out  32  read data, valid while ready_o=1.
- ready_o  out  1  one-cycle completion pulse.
- interrupt_request_o  out  1  level interrupt: |(PENDING & MASK).

Behaviour:
- One clock; reset is asynchronous and active-low. Reset values: all outputs 0; all registers 0; all channels OFF.
- Bus handshake:
  - A request is accepted on a posedge where req_i=1 and ready_o=0.
  - ready_o=1 on the next cycle, then ready_o=0 on the cycle after. Latency is exactly 1.
  - read_data_o is registered and valid only while ready_o=1; it is 0 otherwise.
  - req_i is ignored while ready_o=1, so back-to-back transfers take 2 cycles each.
  - A write commits at the acceptance edge.
- Register map:
  - 0x00 SYS_CNT[31:0] (RO).
  - 0x04 SYS_CNT[63:32] (RO).
  - 0x08 PENDING, W1C, bits [CHANNELS-1:0].
  - 0x0C MASK, RW, bits [CHANNELS-1:0].
  - 0x24 RST: writing 0x1 soft-resets all registers except SYS_CNT; other values are ignored.
  - Per channel n, base 0x40+0x10*n: +0 DELAY (RW), +4 MODE (RW, 0 OFF / 1 NTIMES / 2 FOREVER), +8 REP_CNT (RW), +C CUR (RO, current count).
  - Unmapped reads return 0. Unmapped writes and writes to RO registers are ignored.
  - MODE values 3..0xFFFFFFFF are written as OFF.
- SYS_CNT increments every cycle and wraps 2^64-1 to 0. No lo/hi snapshot: software re-reads if a carry is suspected.
- Channel FSM:
  - States are IDLE and RUN.
  - A write of MODE=1 or MODE=2 forces RUN with CUR=0, even if the channel is already running.
  - In RUN, each cycle: if CUR==DELAY-1, an event fires and CUR<=0; otherwise CUR<=CUR+1.
  - Event: PENDING[n]<=1. In NTIMES, REP_CNT<=REP_CNT-1; when REP_CNT reaches 0, the channel moves to IDLE and MODE<=0.
  - First event occurs DELAY cycles after the MODE write edge.
- Boundaries:
  - DELAY=0 while in RUN: no events, CUR held at 0, channel remains in RUN.
  - NTIMES with REP_CNT=0 at start: channel goes to IDLE immediately with no event, and MODE reads 0.
  - DELAY=1: one event every cycle.
  - A DELAY write while running resets CUR to 0; the new period starts from the write edge.
  - A REP_CNT write while running updates the remaining count directly.
  - MODE=0 write: channel goes to IDLE and CUR is held; PENDING is unchanged.
  - Event and W1C on the same bit in the same cycle: set wins.
  - MASK does not gate PENDING latching, only interrupt_request_o.
  - Soft reset (RST write) and an event in the same cycle: reset wins.
  - Async reset mid-transfer: ready_o drops immediately; the transaction is lost.

Test Plan:
- Reset and bus: assert rst_i=0 during activity, then release. All registers read 0. Each access yields exactly one ready_o pulse, 1 cycle after acceptance.
- Ch0 NTIMES: DELAY=10, REP_CNT=3, MASK=1, MODE=1.
  - PENDING[0] sets exactly 10, 20 and 30 cycles after the MODE edge.
  - Between events, W1C 0x1 clears PENDING[0], and interrupt_request_o follows PENDING[0].
  - After the third event, MODE reads 0 and no further events occur.
- Ch1 FOREVER, DELAY=1: PENDING[1] sets every cycle. W1C 0x2 in the same cycle as an event leaves bit 1 set. MODE=0 stops events and CUR stays frozen.
- Masking across channels: ch2 and ch3 FOREVER with DELAY=5 and DELAY=7, MASK=0x4.
  - interrupt_request_o is driven by ch2 only, while PENDING reads 0xC.
  - After MASK=0xC and W1C of bit 2 only, the IRQ stays high because of ch3.
- Corner values:
  - NTIMES with REP_CNT=0: MODE reads 0 immediately and there is no event.
  - DELAY=0 in FOREVER: no events.
  - A DELAY rewrite mid-period restarts the count.
  - MODE write of 7 reads back 0.
  - Reads of 0x30 and of 0x40+0x10*CHANNELS return 0.
- SYS_CNT: two reads N cycles apart differ by N. A write to 0x00 has no effect. RST=1 clears all channels, MASK and PENDING, but SYS_CNT keeps counting.

Source files
------------

// File: rtl/timer_multi_sb_ctrl_if.sv
// Bus port bundle for the multi-channel system-bus timer.
// Signal names follow the peripheral-side direction (_i into the timer, _o out of it).
interface timer_multi_sb_ctrl_if;
  logic        req_i;
  logic        write_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        ready_o;

  modport master (output req_i, write_enable_i, addr_i, write_data_i,
                  input  read_data_o, ready_o);
  modport slave  (input  req_i, write_enable_i, addr_i, write_data_i,
                  output read_data_o, ready_o);
endinterface

// File: rtl/timer_multi_sb_ctrl.sv
// Multi-channel system-bus timer: per-channel OFF/NTIMES/FOREVER delay counters,
// shared 64-bit free-running counter, W1C pending + mask into one level IRQ.

module timer_multi_sb_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             soft_rst,
  input  logic             wr_delay,
  input  logic             wr_mode,
  input  logic             wr_rep,
  input  logic [31:0]      wdata,
  output logic             evt,
  output logic [CNT_W-1:0] delay,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] rep,
  output logic [CNT_W-1:0] cur
);
  logic             run_q, run_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] delay_q, delay_d, rep_q, rep_d, cur_q, cur_d;

  always_comb begin
    run_d   = run_q;
    mode_d  = mode_q;
    delay_d = delay_q;
    rep_d   = rep_q;
    cur_d   = cur_q;
    evt     = 1'b0;
    if (soft_rst) begin
      run_d   = 1'b0;
      mode_d  = 2'd0;
      delay_d = '0;
      rep_d   = '0;
      cur_d   = '0;
    end else if (wr_mode) begin
      // NTIMES with nothing left to count never starts; illegal codes mean OFF
      if ((wdata == 32'd1 && rep_q != '0) || wdata == 32'd2) begin
        run_d  = 1'b1;
        mode_d = wdata[1:0];
        cur_d  = '0;
      end else begin
        run_d  = 1'b0;
        mode_d = 2'd0;
      end
    end else if (wr_delay) begin
      delay_d = wdata[CNT_W-1:0];
      if (run_q) cur_d = '0;
    end else begin
      if (run_q && delay_q != '0) begin
        if (cur_q == delay_q - CNT_W'(1)) begin
          evt   = 1'b1;
          cur_d = '0;
          if (mode_q == 2'd1) begin
            if (rep_q <= CNT_W'(1)) begin
              rep_d  = '0;
              run_d  = 1'b0;
              mode_d = 2'd0;
            end else begin
              rep_d = rep_q - CNT_W'(1);
            end
          end
        end else begin
          cur_d = cur_q + CNT_W'(1);
        end
      end
      if (wr_rep) rep_d = wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_q   <= 1'b0;
      mode_q  <= 2'd0;
      delay_q <= '0;
      rep_q   <= '0;
      cur_q   <= '0;
    end else begin
      run_q   <= run_d;
      mode_q  <= mode_d;
      delay_q <= delay_d;
      rep_q   <= rep_d;
      cur_q   <= cur_d;
    end
  end

  assign delay = delay_q;
  assign mode  = mode_q;
  assign rep   = rep_q;
  assign cur   = cur_q;
endmodule

module timer_multi_sb_ctrl #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  timer_multi_sb_ctrl_if.slave bus,
  output logic                 interrupt_request_o
);
  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d, rd_val;
  logic [63:0]         sys_cnt_q, sys_cnt_d;
  logic [CHANNELS-1:0] pend_q, pend_d, mask_q, mask_d, evt;
  logic                accept, wr, soft_rst, in_ch;
  logic [31:0]         a, ch_idx;

  logic [CHANNELS-1:0][CNT_W-1:0] delay, rep, cur;
  logic [CHANNELS-1:0][1:0]       mode;

  // req_i is ignored during the ready pulse, so each transfer takes two cycles
  assign accept   = bus.req_i && !ready_q;
  assign wr       = accept && bus.write_enable_i;
  assign a        = bus.addr_i & ~32'h3;
  assign in_ch    = (a >= 32'h40) && (a < 32'h40 + 32'(CHANNELS) * 32'h10);
  assign ch_idx   = (a - 32'h40) >> 4;
  assign soft_rst = wr && a == 32'h24 && bus.write_data_i == 32'h1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic sel;
    assign sel = wr && in_ch && ch_idx == 32'(g);
    timer_multi_sb_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .soft_rst (soft_rst),
      .wr_delay (sel && a[3:2] == 2'd0),
      .wr_mode  (sel && a[3:2] == 2'd1),
      .wr_rep   (sel && a[3:2] == 2'd2),
      .wdata    (bus.write_data_i),
      .evt      (evt[g]),
      .delay    (delay[g]),
      .mode     (mode[g]),
      .rep      (rep[g]),
      .cur      (cur[g])
    );
  end

  always_comb begin
    rd_val = '0;
    case (a)
      32'h00:  rd_val = sys_cnt_q[31:0];
      32'h04:  rd_val = sys_cnt_q[63:32];
      32'h08:  rd_val = 32'(pend_q);
      32'h0C:  rd_val = 32'(mask_q);
      default: begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (in_ch && ch_idx == 32'(n)) begin
            case (a[3:2])
              2'd0:    rd_val = 32'(delay[n]);
              2'd1:    rd_val = 32'(mode[n]);
              2'd2:    rd_val = 32'(rep[n]);
              default: rd_val = 32'(cur[n]);
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    ready_d   = accept;
    rdata_d   = (accept && !bus.write_enable_i) ? rd_val : 32'h0;
    sys_cnt_d = sys_cnt_q + 64'd1;
    mask_d    = mask_q;
    pend_d    = pend_q;
    if (wr && a == 32'h0C) mask_d = bus.write_data_i[CHANNELS-1:0];
    if (wr && a == 32'h08) pend_d = pend_q & ~bus.write_data_i[CHANNELS-1:0];
    // OR-in after the clear so a same-cycle event survives W1C
    pend_d = pend_d | evt;
    if (soft_rst) begin
      mask_d = '0;
      pend_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      sys_cnt_q <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      sys_cnt_q <= sys_cnt_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.ready_o         = ready_q;
  assign bus.read_data_o     = rdata_q;
  assign interrupt_request_o = |(pend_q & mask_q);
endmodule
